// File: rtl/proc_pkg.sv
// proc_pkg: shared opcodes, sequencer states and ALU enable layout for the bus sequencer
package proc_pkg;
  typedef enum logic [2:0] {OP_LOAD, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_DISP} opcode_e;
  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_DONE} seq_state_e;
  localparam int ALU_EN_A   = 0;
  localparam int ALU_EN_B   = 1;
  localparam int ALU_EN_OUT = 2;
  localparam int FUNC_W     = 4;
endpackage

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: 3-bit register index plus enable to one-hot select
module reg_select_decoder #(
  parameter int NUM_REGS = 8
) (
  input  logic [2:0]          idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bit
    assign onehot[g] = en && (idx == 3'(g));
  end
endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: walks one latched instruction through T1..T3, granting the shared bus to one driver per step
module bus_sequencer
  import proc_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int FUNC_W   = proc_pkg::FUNC_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [11:0]         machine_code,
  output logic                data_enable,
  output logic [NUM_REGS-1:0] reg_wr_en,
  output logic [NUM_REGS-1:0] reg_rd_en,
  output logic [2:0]          alu_en,
  output logic [FUNC_W-1:0]   alu_func,
  output logic                display_en,
  output logic                busy,
  output logic                done
);
  seq_state_e  state_q, state_d;
  logic [11:0] instr_q, instr_d;
  opcode_e     op;
  logic [2:0]  p1, p2, p3, rd_idx;
  logic        is_alu, rd_v, wr_v;
  assign op     = opcode_e'(instr_q[11:9]);
  assign p1     = instr_q[8:6];
  assign p2     = instr_q[5:3];
  assign p3     = instr_q[2:0];
  assign is_alu = op != OP_LOAD && op != OP_MOV && op != OP_DISP;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_T1;
        instr_d = machine_code;
      end
      S_T1:    state_d = is_alu ? S_T2 : S_DONE;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  // T2 always reads p3; in T1 DISP reads p1 and everything but LOAD reads p2
  assign rd_idx      = (state_q == S_T2) ? p3 : (op == OP_DISP ? p1 : p2);
  assign rd_v        = (state_q == S_T1 && op != OP_LOAD) || state_q == S_T2;
  assign wr_v        = (state_q == S_T1 && (op == OP_LOAD || op == OP_MOV)) || state_q == S_T3;
  assign data_enable = state_q == S_T1 && op == OP_LOAD;
  assign display_en  = state_q == S_T1 && op == OP_DISP;
  assign busy        = state_q != S_IDLE;
  assign done        = state_q == S_DONE;
  assign alu_func    = busy ? FUNC_W'(instr_q[11:9]) : '0;
  always_comb begin
    alu_en             = '0;
    alu_en[ALU_EN_A]   = state_q == S_T1 && is_alu;
    alu_en[ALU_EN_B]   = state_q == S_T2;
    alu_en[ALU_EN_OUT] = state_q == S_T3;
  end
  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rd (.idx(rd_idx), .en(rd_v), .onehot(reg_rd_en));
  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_wr (.idx(p1), .en(wr_v), .onehot(reg_wr_en));
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed and random instruction streams checked against a per-cycle expectation queue
module tb_bus_sequencer;
  logic        clock = 0, reset = 1, start = 0;
  logic [11:0] machine_code = '0;
  logic        data_enable, display_en, busy, done;
  logic [7:0]  reg_wr_en, reg_rd_en;
  logic [2:0]  alu_en;
  logic [3:0]  alu_func;
  int n_tests = 0, n_fail = 0, n_acc = 0, n_done = 0;
  logic [31:0] exp_q[$];

  bus_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .machine_code(machine_code),
    .data_enable(data_enable), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .alu_en(alu_en), .alu_func(alu_func), .display_en(display_en),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (!reset)
      assert ($countones({data_enable, reg_rd_en, alu_en[2]}) <= 1 && $countones(reg_wr_en) <= 1)
        else $error("bus driver invariant violated");

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic de, input logic [7:0] rd, input logic [7:0] wr,
                                       input logic [2:0] ae, input logic [3:0] f, input logic dp,
                                       input logic bz, input logic dn);
    return {5'b0, de, rd, wr, ae, f, dp, bz, dn};
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] p);
    logic [7:0] one = 8'd1;
    return one << p;
  endfunction

  // one record per cycle the instruction occupies, ending with its done cycle
  task automatic push_instr(input logic [11:0] mc);
    logic [2:0] op = mc[11:9], p1 = mc[8:6], p2 = mc[5:3], p3 = mc[2:0];
    logic [3:0] f = {1'b0, op};
    if (op == 3'd0)      exp_q.push_back(pack(1, 0, oh(p1), 0, f, 0, 1, 0));
    else if (op == 3'd1) exp_q.push_back(pack(0, oh(p2), oh(p1), 0, f, 0, 1, 0));
    else if (op == 3'd7) exp_q.push_back(pack(0, oh(p1), 0, 0, f, 1, 1, 0));
    else begin
      exp_q.push_back(pack(0, oh(p2), 0, 3'b001, f, 0, 1, 0));
      exp_q.push_back(pack(0, oh(p3), 0, 3'b010, f, 0, 1, 0));
      exp_q.push_back(pack(0, 0, oh(p1), 3'b100, f, 0, 1, 0));
    end
    exp_q.push_back(pack(0, 0, 0, 0, f, 0, 1, 1));
  endtask

  task automatic step(input logic s, input logic [11:0] mc, input logic r);
    logic [31:0] e;
    start = s; machine_code = mc; reset = r;
    @(posedge clock);
    if (r) begin
      if (exp_q.size() > 0 && !exp_q[0][0]) n_acc--;
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (s) begin push_instr(mc); n_acc++; end
    end else void'(exp_q.pop_front());
    #1;
    e = exp_q.size() > 0 ? exp_q[0] : '0;
    check("outs", pack(data_enable, reg_rd_en, reg_wr_en, alu_en, alu_func, display_en, busy, done), e);
    check("bus_inv", 32'($countones({data_enable, reg_rd_en, alu_en[2]}) <= 1 && $countones(reg_wr_en) <= 1), 32'd1);
    if (done) n_done++;
  endtask

  initial begin
    int d0;
    step(0, 0, 1); step(0, 0, 1);
    check("rst_busy", 32'(busy), 0);
    step(1, 12'h0C0, 0);
    check("load_de", 32'(data_enable), 1); check("load_wr", 32'(reg_wr_en), 32'h08);
    step(0, 0, 0); check("load_done", 32'(done), 1);
    step(0, 0, 0); check("load_idle", 32'(busy), 0);
    step(1, 12'h453, 0);
    check("add_t1_rd", 32'(reg_rd_en), 32'h04); check("add_t1_alu", 32'(alu_en), 1); check("add_func", 32'(alu_func), 2);
    step(0, 0, 0); check("add_t2_rd", 32'(reg_rd_en), 32'h08); check("add_t2_alu", 32'(alu_en), 2);
    step(0, 0, 0); check("add_t3_alu", 32'(alu_en), 4); check("add_t3_wr", 32'(reg_wr_en), 32'h02);
    step(0, 0, 0); check("add_done", 32'(done), 1);
    step(0, 0, 0);
    d0 = n_done;
    for (int i = 0; i < 10; i++) step(1, 12'h238, 0);
    check("mov_cadence", 32'(n_done - d0), 3);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(1, 12'hF40, 0);
    check("disp_rd", 32'(reg_rd_en), 32'h20); check("disp_en", 32'(display_en), 1);
    check("disp_alu", 32'(alu_en), 0); check("disp_de", 32'(data_enable), 0);
    step(0, 0, 0); step(0, 0, 0);
    step(1, 12'h653, 0); step(0, 0, 0);
    check("sub_t2", 32'(alu_en), 2);
    step(0, 0, 1);
    check("rst_mid_busy", 32'(busy), 0); check("rst_mid_done", 32'(done), 0);
    step(1, 12'h180, 0);
    check("load2_wr", 32'(reg_wr_en), 32'h40);
    step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 12'($urandom), $urandom_range(0, 49) == 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    check("done_cnt", 32'(n_done), 32'(n_acc));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
